// File: rtl/prom_boot_loader_if.sv
// Purpose: UART-receive and PROM-write signal bundle for the boot loader.
//   rx_data_i/rx_ready_i : received byte and its valid strobe (into the loader)
//   rx_ack_o             : byte consumed (out of the loader)
//   prom_we_o/prom_addr_o/prom_data_o : one-cycle PROM word write (out of the loader)
// The master modport is the side that supplies bytes and sinks PROM writes;
// the slave modport is the boot loader itself.
interface prom_boot_loader_if #(
   parameter int unsigned ADDR_BITS = 6
);
   logic [7:0]           rx_data_i;
   logic                 rx_ready_i;
   logic                 rx_ack_o;
   logic                 prom_we_o;
   logic [ADDR_BITS-1:0] prom_addr_o;
   logic [15:0]          prom_data_o;

   modport master (
      output rx_data_i, rx_ready_i,
      input  rx_ack_o, prom_we_o, prom_addr_o, prom_data_o
   );

   modport slave (
      input  rx_data_i, rx_ready_i,
      output rx_ack_o, prom_we_o, prom_addr_o, prom_data_o
   );
endinterface

// File: rtl/prom_boot_loader.sv
// Purpose: framed boot controller between the UART receiver and the instruction PROM.
//   Parses SYNC / LEN / LEN x {lo,hi} / CSUM frames, writes 16-bit words into the
//   PROM from address 0 and releases CPU reset only after a frame checksum verifies.
// Ports:
//   clk, reset_n : clock and synchronous active-low reset
//   bus (slave)  : rx byte input, rx_ack_o, PROM write strobe/address/data
//   cpu_reset_o  : active-high CPU reset
//   busy_o       : frame in progress
//   error_o      : 0 none, 1 bad LEN, 2 checksum fail, 3 inter-byte timeout
module prom_boot_loader #(
   parameter int unsigned ROM_WORDS      = 42,
   parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
   parameter int unsigned TIMEOUT_CYCLES = 160
) (
   input  logic               clk,
   input  logic               reset_n,
   prom_boot_loader_if.slave  bus,
   output logic               cpu_reset_o,
   output logic               busy_o,
   output logic [1:0]         error_o
);
   localparam int unsigned ADDR_BITS = $clog2(ROM_WORDS);
   localparam int unsigned CNT_BITS  = $clog2(ROM_WORDS + 1);
   localparam int unsigned TMR_BITS  = $clog2(TIMEOUT_CYCLES);

   localparam logic [1:0] ERR_NONE = 2'd0;
   localparam logic [1:0] ERR_LEN  = 2'd1;
   localparam logic [1:0] ERR_CSUM = 2'd2;
   localparam logic [1:0] ERR_TMO  = 2'd3;

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_LEN  = 3'd1,
      S_LO   = 3'd2,
      S_HI   = 3'd3,
      S_CSUM = 3'd4,
      S_RUN  = 3'd5
   } state_t;

   state_t r_state, w_state_nxt;

   logic                 r_we, w_we_nxt;
   logic [ADDR_BITS-1:0] r_prom_addr, w_prom_addr_nxt;
   logic [15:0]          r_prom_data, w_prom_data_nxt;
   logic                 r_cpu_reset, w_cpu_reset_nxt;
   logic                 r_busy, w_busy_nxt;
   logic [1:0]           r_error, w_error_nxt;
   logic [7:0]           r_sum, w_sum_nxt;
   logic [7:0]           r_lo, w_lo_nxt;
   logic [ADDR_BITS-1:0] r_addr, w_addr_nxt;
   logic [CNT_BITS-1:0]  r_remaining, w_remaining_nxt;
   logic [TMR_BITS-1:0]  r_timer, w_timer_nxt;

   logic       w_byte;
   logic       w_is_sync;
   logic       w_in_frame;
   logic       w_timeout;
   logic       w_len_bad;
   logic [7:0] w_sum_add;

   // Byte qualifiers shared by next-state and output logic
   assign w_byte     = bus.rx_ready_i;
   assign w_is_sync  = (bus.rx_data_i == SYNC_BYTE);
   assign w_in_frame = (r_state == S_LEN) || (r_state == S_LO) ||
                       (r_state == S_HI)  || (r_state == S_CSUM);
   assign w_timeout  = w_in_frame && !w_byte &&
                       (r_timer == TMR_BITS'(TIMEOUT_CYCLES - 1));
   assign w_len_bad  = (bus.rx_data_i == 8'd0) || (bus.rx_data_i > 8'(ROM_WORDS));
   assign w_sum_add  = r_sum + bus.rx_data_i;

   // Loader never back-pressures the UART
   assign bus.rx_ack_o    = bus.rx_ready_i & reset_n;
   assign bus.prom_we_o   = r_we;
   assign bus.prom_addr_o = r_prom_addr;
   assign bus.prom_data_o = r_prom_data;
   assign cpu_reset_o     = r_cpu_reset;
   assign busy_o          = r_busy;
   assign error_o         = r_error;

   // State register
   always_ff @(posedge clk) begin
      if (!reset_n) r_state <= S_IDLE;
      else          r_state <= w_state_nxt;
   end

   // Next-state logic; SYNC inside a frame is plain data
   always_comb begin
      w_state_nxt = r_state;
      if (w_timeout) begin
         w_state_nxt = S_IDLE;
      end else if (w_byte) begin
         case (r_state)
            S_IDLE, S_RUN: if (w_is_sync) w_state_nxt = S_LEN;
            S_LEN:         w_state_nxt = w_len_bad ? S_IDLE : S_LO;
            S_LO:          w_state_nxt = S_HI;
            S_HI:          w_state_nxt = (r_remaining == CNT_BITS'(1)) ? S_CSUM : S_LO;
            S_CSUM:        w_state_nxt = (w_sum_add == 8'd0) ? S_RUN : S_IDLE;
            default:       w_state_nxt = S_IDLE;
         endcase
      end
   end

   // Next values of registered outputs and datapath
   always_comb begin
      w_we_nxt        = 1'b0;
      w_prom_addr_nxt = r_prom_addr;
      w_prom_data_nxt = r_prom_data;
      w_cpu_reset_nxt = r_cpu_reset;
      w_busy_nxt      = r_busy;
      w_error_nxt     = r_error;
      w_sum_nxt       = r_sum;
      w_lo_nxt        = r_lo;
      w_addr_nxt      = r_addr;
      w_remaining_nxt = r_remaining;
      w_timer_nxt     = '0;

      if (w_timeout) begin
         w_error_nxt = ERR_TMO;
         w_busy_nxt  = 1'b0;
      end else if (w_byte) begin
         case (r_state)
            S_IDLE, S_RUN: begin
               if (w_is_sync) begin
                  w_sum_nxt       = 8'd0;
                  w_error_nxt     = ERR_NONE;
                  w_busy_nxt      = 1'b1;
                  w_cpu_reset_nxt = 1'b1;
               end
            end
            S_LEN: begin
               if (w_len_bad) begin
                  w_error_nxt = ERR_LEN;
                  w_busy_nxt  = 1'b0;
               end else begin
                  w_remaining_nxt = CNT_BITS'(bus.rx_data_i);
                  w_addr_nxt      = '0;
                  w_sum_nxt       = bus.rx_data_i;
               end
            end
            S_LO: begin
               w_lo_nxt  = bus.rx_data_i;
               w_sum_nxt = w_sum_add;
            end
            S_HI: begin
               w_we_nxt        = 1'b1;
               w_prom_addr_nxt = r_addr;
               w_prom_data_nxt = {bus.rx_data_i, r_lo};
               w_sum_nxt       = w_sum_add;
               w_addr_nxt      = ADDR_BITS'(r_addr + 1'b1);
               w_remaining_nxt = CNT_BITS'(r_remaining - 1'b1);
            end
            S_CSUM: begin
               w_busy_nxt = 1'b0;
               if (w_sum_add == 8'd0) w_cpu_reset_nxt = 1'b0;
               else                   w_error_nxt     = ERR_CSUM;
            end
            default: ;
         endcase
      end else if (w_in_frame) begin
         w_timer_nxt = TMR_BITS'(r_timer + 1'b1);
      end
   end

   // Output and datapath registers
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_we        <= 1'b0;
         r_prom_addr <= '0;
         r_prom_data <= '0;
         r_cpu_reset <= 1'b1;
         r_busy      <= 1'b0;
         r_error     <= ERR_NONE;
         r_sum       <= '0;
         r_lo        <= '0;
         r_addr      <= '0;
         r_remaining <= '0;
         r_timer     <= '0;
      end else begin
         r_we        <= w_we_nxt;
         r_prom_addr <= w_prom_addr_nxt;
         r_prom_data <= w_prom_data_nxt;
         r_cpu_reset <= w_cpu_reset_nxt;
         r_busy      <= w_busy_nxt;
         r_error     <= w_error_nxt;
         r_sum       <= w_sum_nxt;
         r_lo        <= w_lo_nxt;
         r_addr      <= w_addr_nxt;
         r_remaining <= w_remaining_nxt;
         r_timer     <= w_timer_nxt;
      end
   end
endmodule

// File: tb/tb_prom_boot_loader.sv
// Purpose: self-checking bench for prom_boot_loader. Directed frames plus
//   randomized traffic, checked every cycle against a frame-position model.
module tb_prom_boot_loader;
   localparam int unsigned ROM_WORDS = 42;
   localparam int unsigned ADDR_BITS = 6;
   localparam int unsigned TMO       = 160;

   typedef logic [7:0] bq_t[$];

   logic       clk = 1'b0;
   logic       reset_n;
   logic       cpu_reset_o;
   logic       busy_o;
   logic [1:0] error_o;

   prom_boot_loader_if #(.ADDR_BITS(ADDR_BITS)) bus ();

   prom_boot_loader #(
      .ROM_WORDS      (ROM_WORDS),
      .SYNC_BYTE      (8'hA5),
      .TIMEOUT_CYCLES (TMO)
   ) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .bus         (bus.slave),
      .cpu_reset_o (cpu_reset_o),
      .busy_o      (busy_o),
      .error_o     (error_o)
   );

   always #5 clk = ~clk;

   int n_total = 0;
   int n_bad   = 0;

   // Reference model: position within the current frame, not a state machine
   bit m_active;
   int m_pos;
   int m_len;
   int m_sum;
   int m_lo;
   int m_quiet;
   bit e_cpu, e_busy, e_we;
   int e_err, e_addr, e_data;

   logic [21:0] obs_q[$];

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic void model_step(input bit rst, input bit rdy, input int d);
      if (!rst) begin
         m_active = 0; m_quiet = 0;
         e_cpu = 1; e_busy = 0; e_err = 0; e_we = 0; e_addr = 0; e_data = 0;
         return;
      end
      e_we = 0;
      if (!m_active) begin
         if (rdy && d == 8'hA5) begin
            m_active = 1; m_pos = 0; m_sum = 0; m_quiet = 0;
            e_err = 0; e_busy = 1; e_cpu = 1;
         end
      end else if (rdy) begin
         m_quiet = 0;
         if (m_pos == 0) begin
            if (d == 0 || d > ROM_WORDS) begin
               m_active = 0; e_err = 1; e_busy = 0;
            end else begin
               m_len = d; m_sum = d; m_pos = 1;
            end
         end else if (m_pos <= 2 * m_len) begin
            m_sum = (m_sum + d) % 256;
            if (m_pos % 2 == 1) m_lo = d;
            else begin
               e_we = 1; e_addr = m_pos / 2 - 1; e_data = d * 256 + m_lo;
            end
            m_pos++;
         end else begin
            if ((m_sum + d) % 256 == 0) e_cpu = 0;
            else e_err = 2;
            m_active = 0; e_busy = 0;
         end
      end else begin
         if (m_quiet == TMO - 1) begin
            m_active = 0; e_err = 3; e_busy = 0;
         end else m_quiet++;
      end
   endfunction

   task automatic tick(input bit rst, input bit rdy, input logic [7:0] d);
      reset_n        = rst;
      bus.rx_ready_i = rdy;
      bus.rx_data_i  = d;
      #1;
      check_val("rx_ack", 32'(bus.rx_ack_o), 32'(rdy & rst));
      @(posedge clk);
      model_step(rst, rdy, int'(d));
      #1;
      check_val("cpu_reset", 32'(cpu_reset_o), 32'(e_cpu));
      check_val("busy", 32'(busy_o), 32'(e_busy));
      check_val("error", 32'(error_o), 32'(e_err));
      check_val("prom_we", 32'(bus.prom_we_o), 32'(e_we));
      if (e_we) begin
         check_val("prom_addr", 32'(bus.prom_addr_o), 32'(e_addr));
         check_val("prom_data", 32'(bus.prom_data_o), 32'(e_data));
      end
      if (bus.prom_we_o) obs_q.push_back({bus.prom_addr_o, bus.prom_data_o});
   endtask

   task automatic send(input logic [7:0] b);
      tick(1'b1, 1'b1, b);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) tick(1'b1, 1'b0, 8'($urandom));
   endtask

   task automatic send_q(input bq_t q, input int maxgap);
      foreach (q[i]) begin
         send(q[i]);
         if (maxgap > 0) idle($urandom_range(0, maxgap));
      end
   endtask

   function automatic bq_t frame_of(input logic [15:0] w[$], input bit bad);
      bq_t f;
      int  s;
      int  cs;
      f.push_back(8'hA5);
      f.push_back(8'(w.size()));
      s = w.size();
      foreach (w[i]) begin
         f.push_back(w[i][7:0]);
         f.push_back(w[i][15:8]);
         s = s + int'(w[i][7:0]) + int'(w[i][15:8]);
      end
      cs = (256 - (s % 256)) % 256;
      if (bad) cs = (cs + 1) % 256;
      f.push_back(8'(cs));
      return f;
   endfunction

   initial begin
      logic [15:0] w[$];
      bq_t         fb;
      int          kind, len, k;
      logic [7:0]  nb;

      // Reset state
      for (int i = 0; i < 3; i++) tick(1'b0, 1'b0, 8'h00);
      check_val("rst_addr", 32'(bus.prom_addr_o), 32'd0);
      check_val("rst_data", 32'(bus.prom_data_o), 32'd0);
      idle(2);

      // Two-word valid frame
      obs_q.delete();
      w = '{16'h1234, 16'h5678};
      send_q(frame_of(w, 1'b0), 0);
      check_val("t1_nwr", 32'(obs_q.size()), 32'd2);
      check_val("t1_w0", 32'(obs_q[0]), 32'({6'd0, 16'h1234}));
      check_val("t1_w1", 32'(obs_q[1]), 32'({6'd1, 16'h5678}));
      check_val("t1_cpu", 32'(cpu_reset_o), 32'd0);
      check_val("t1_err", 32'(error_o), 32'd0);
      idle(3);

      // Same frame with a wrong checksum
      obs_q.delete();
      send_q(frame_of(w, 1'b1), 0);
      check_val("t2_nwr", 32'(obs_q.size()), 32'd2);
      check_val("t2_cpu", 32'(cpu_reset_o), 32'd1);
      check_val("t2_err", 32'(error_o), 32'd2);
      check_val("t2_busy", 32'(busy_o), 32'd0);
      idle(2);

      // LEN of 0 and of ROM_WORDS+1, then a valid frame clears the error
      obs_q.delete();
      send(8'hA5); send(8'h00);
      check_val("t3_len0", 32'(error_o), 32'd1);
      send(8'hA5); send(8'(ROM_WORDS + 1));
      check_val("t3_len43", 32'(error_o), 32'd1);
      check_val("t3_nwr", 32'(obs_q.size()), 32'd0);
      w = '{16'hCAFE};
      send_q(frame_of(w, 1'b0), 0);
      check_val("t3_clr", 32'(error_o), 32'd0);
      w.delete();
      for (int i = 0; i < ROM_WORDS; i++) w.push_back(16'($urandom));
      obs_q.delete();
      send_q(frame_of(w, 1'b0), 0);
      check_val("t3_maxlen_nwr", 32'(obs_q.size()), 32'(ROM_WORDS));
      check_val("t3_maxlen_last", 32'(obs_q[ROM_WORDS-1]), 32'({6'(ROM_WORDS - 1), w[ROM_WORDS-1]}));

      // Timeout boundary: 159 quiet cycles survive, 160 abort
      obs_q.delete();
      send(8'hA5); send(8'h01); send(8'h34);
      idle(TMO - 1);
      check_val("t4_busy_159", 32'(busy_o), 32'd1);
      check_val("t4_err_159", 32'(error_o), 32'd0);
      idle(1);
      check_val("t4_err", 32'(error_o), 32'd3);
      check_val("t4_busy", 32'(busy_o), 32'd0);
      check_val("t4_cpu", 32'(cpu_reset_o), 32'd1);
      check_val("t4_nwr", 32'(obs_q.size()), 32'd0);
      send(8'hA5); send(8'h01); send(8'h34);
      idle(TMO - 1);
      send(8'h12);
      idle(TMO - 1);
      send(8'h01 ^ 8'hFF ^ 8'h34 ^ 8'h34);
      check_val("t4_gap_err", 32'(error_o), 32'(e_err));

      // Reload from RUN
      w = '{16'h0001};
      send_q(frame_of(w, 1'b0), 0);
      check_val("t5_pre_run", 32'(cpu_reset_o), 32'd0);
      obs_q.delete();
      send(8'hA5);
      check_val("t5_cpu_hold", 32'(cpu_reset_o), 32'd1);
      w = '{16'hBEEF};
      fb = frame_of(w, 1'b0);
      void'(fb.pop_front());
      send_q(fb, 0);
      check_val("t5_w0", 32'(obs_q[0]), 32'({6'd0, 16'hBEEF}));
      check_val("t5_cpu", 32'(cpu_reset_o), 32'd0);

      // Reset mid-data, then back-to-back frame with SYNC values as data
      send(8'hA5); send(8'h03); send(8'h11); send(8'h22); send(8'h33);
      tick(1'b0, 1'b1, 8'hA5);
      check_val("t6_cpu", 32'(cpu_reset_o), 32'd1);
      check_val("t6_busy", 32'(busy_o), 32'd0);
      check_val("t6_err", 32'(error_o), 32'd0);
      check_val("t6_we", 32'(bus.prom_we_o), 32'd0);
      check_val("t6_addr", 32'(bus.prom_addr_o), 32'd0);
      check_val("t6_data", 32'(bus.prom_data_o), 32'd0);
      obs_q.delete();
      w = '{16'hA5A5, 16'h00A5};
      send_q(frame_of(w, 1'b0), 0);
      check_val("t6_w0", 32'(obs_q[0]), 32'({6'd0, 16'hA5A5}));
      check_val("t6_w1", 32'(obs_q[1]), 32'({6'd1, 16'h00A5}));
      check_val("t6_run", 32'(cpu_reset_o), 32'd0);

      // Randomized traffic
      for (int it = 0; it < 60; it++) begin
         for (int n = $urandom_range(0, 3); n > 0; n--) begin
            nb = 8'($urandom);
            if (nb == 8'hA5) nb = 8'h5A;
            send(nb);
         end
         kind = $urandom_range(0, 7);
         len  = $urandom_range(1, (it % 5 == 0) ? ROM_WORDS : 6);
         w.delete();
         for (int i = 0; i < len; i++) w.push_back(16'($urandom));
         fb = frame_of(w, kind == 4);
         case (kind)
            5: begin
               send(8'hA5);
               nb = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom_range(ROM_WORDS + 1, 255));
               send(nb);
            end
            6: begin
               k = $urandom_range(1, fb.size() - 1);
               for (int i = 0; i < k; i++) send(fb[i]);
               idle(TMO + $urandom_range(0, 3));
            end
            7: begin
               k = $urandom_range(1, fb.size() - 1);
               for (int i = 0; i < k; i++) send(fb[i]);
               for (int r = $urandom_range(1, 2); r > 0; r--)
                  tick(1'b0, 1'($urandom), 8'($urandom));
            end
            default: send_q(fb, (kind == 3) ? 3 : 0);
         endcase
         idle($urandom_range(0, 3));
      end

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end
endmodule
